pipelined_segment_adder: RTL

//  Parametrised, pipelined successor to the chained ripple-carry adders. Splits a WIDTH-bit add/subtract

---
 rtl/pipelined_segment_adder.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipelined_segment_adder.sv
// Wide add/subtract split into SEG-bit ripple segments, one register stage per segment.
// The carry is registered between stages, and a global stall holds the whole pipe under backpressure.
module pipelined_segment_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  generate
    if (WIDTH % SEG != 0) begin : g_bad_cfg
      $error("pipelined_segment_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
    end
  endgenerate

  logic [NSEG-1:0]  vld_q;
  logic [NSEG-1:0]  c_q;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             ovf_q;

  logic [WIDTH-1:0] a_in [NSEG];
  logic [WIDTH-1:0] b_in [NSEG];
  logic [WIDTH-1:0] s_in [NSEG];
  logic [WIDTH-1:0] s_nx [NSEG];
  logic [SEG:0]     seg_r [NSEG];
  logic [NSEG-1:0]  c_in;
  logic [NSEG-1:0]  v_in;
  logic [NSEG-1:0]  c_nx;
  logic             ovf_nx;
  logic             advance;

  assign advance   = !vld_q[NSEG-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;

  // Stage k sees the operands, partial sum and carry that stage k-1 registered.
  // Stage 0 instead sees the prepared port values, with subtract done as a + ~b + 1.
  always_comb begin
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub | cin;
    s_in[0] = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
      v_in[k] = vld_q[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      seg_r[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_in[k]};
      s_nx[k]  = s_in[k];
      s_nx[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
      c_nx[k]  = seg_r[k][SEG];
    end
    // The carry into the MSB is recovered from the top segment's MSB sum bit.
    ovf_nx = (a_in[NSEG-1][WIDTH-1] ^ b_in[NSEG-1][WIDTH-1] ^ seg_r[NSEG-1][SEG-1])
           ^ seg_r[NSEG-1][SEG];
  end

  // Data registers load only behind a valid operation, so the outputs keep their last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= v_in;
      for (int k = 0; k < NSEG; k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nx[k];
          c_q[k] <= c_nx[k];
        end
      end
      if (v_in[NSEG-1]) ovf_q <= ovf_nx;
    end
  end

endmodule
